// File: rtl/pmem_boot_fetch_ctrl.sv
// Program memory owner: assembles loader bytes into 16-bit words during boot,
// then serves CPU instruction fetches with a fixed one-cycle latency.
module pmem_boot_fetch_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              ld_end,
  input  logic              boot_req,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_valid,
  output logic [15:0]       f_instr,
  output logic              cpu_run,
  output logic [ADDR_W:0]   ld_count,
  output logic              pm_rden,
  output logic [ADDR_W-1:0] pm_rd_addr,
  output logic [1:0]        pm_we,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [15:0]       pm_wr_data,
  input  logic [15:0]       pm_instr
);

  // state   | meaning
  // BOOT_LO | waiting for the low byte of the next word
  // BOOT_HI | low byte latched, waiting for the high byte
  // RUN     | image loaded, CPU fetches served
  typedef enum logic [1:0] {BOOT_LO, BOOT_HI, RUN} state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t      state, next_state;
  logic [7:0]  lo;
  logic        hs, wr_go, lo_load, last_word, reload;
  logic [15:0] wr_word;

  assign ld_ready   = (state != RUN);
  assign hs         = ld_valid & ld_ready;
  assign last_word  = (ld_count == (ADDR_W+1)'(DEPTH - 1));
  assign reload     = (state == RUN) & boot_req;
  assign pm_rden    = (state == RUN) & cpu_run & f_req & ~boot_req;
  assign pm_rd_addr = f_addr;
  assign f_instr    = f_valid ? pm_instr : 16'h0000;

  always_comb begin
    next_state = state;
    wr_go      = 1'b0;
    lo_load    = 1'b0;
    wr_word    = {PAD_BYTE, lo};
    case (state)
      BOOT_LO: begin
        if (hs && ld_end) begin
          wr_go      = 1'b1;
          wr_word    = {PAD_BYTE, ld_byte};
          next_state = RUN;
        end else if (hs) begin
          lo_load    = 1'b1;
          next_state = BOOT_HI;
        end else if (ld_end) begin
          next_state = RUN;
        end
      end
      BOOT_HI: begin
        if (hs) begin
          wr_go      = 1'b1;
          wr_word    = {ld_byte, lo};
          next_state = (ld_end || last_word) ? RUN : BOOT_LO;
        end else if (ld_end) begin
          wr_go      = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (boot_req) next_state = BOOT_LO;
      end
      default: next_state = BOOT_LO;
    endcase
  end

  // cpu_run is withheld during the final write cycle so a fetch never overlaps a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT_LO;
      lo         <= 8'h00;
      ld_count   <= '0;
      cpu_run    <= 1'b0;
      f_valid    <= 1'b0;
      pm_we      <= 2'b00;
      pm_wr_addr <= '0;
      pm_wr_data <= 16'h0000;
    end else begin
      state   <= next_state;
      cpu_run <= (next_state == RUN) & ~wr_go;
      f_valid <= pm_rden;
      pm_we   <= wr_go ? 2'b11 : 2'b00;
      if (lo_load) lo <= ld_byte;
      if (wr_go) begin
        pm_wr_addr <= ld_count[ADDR_W-1:0];
        pm_wr_data <= wr_word;
      end
      if (reload) ld_count <= '0;
      else if (wr_go) ld_count <= ld_count + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_pmem_boot_fetch_ctrl.sv
// Randomized scoreboard bench for pmem_boot_fetch_ctrl with a word-level image model
// and a simple registered program memory.
module tb_pmem_boot_fetch_ctrl;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] PAD = 8'h00;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ld_valid = 1'b0, ld_end = 1'b0, boot_req = 1'b0, f_req = 1'b0;
  logic [7:0] ld_byte = 8'h00;
  logic [AW-1:0] f_addr = '0;
  logic ld_ready, f_valid, cpu_run, pm_rden;
  logic [15:0] f_instr, pm_wr_data;
  logic [15:0] pm_instr = 16'h0000;
  logic [AW:0] ld_count;
  logic [AW-1:0] pm_rd_addr, pm_wr_addr;
  logic [1:0] pm_we;

  pmem_boot_fetch_ctrl #(.ADDR_W(AW), .PAD_BYTE(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .ld_end(ld_end), .boot_req(boot_req), .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid),
    .f_instr(f_instr), .cpu_run(cpu_run), .ld_count(ld_count), .pm_rden(pm_rden),
    .pm_rd_addr(pm_rd_addr), .pm_we(pm_we), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
    .pm_instr(pm_instr));

  always #5 clk = ~clk;

  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (pm_we == 2'b11) mem[pm_wr_addr] <= pm_wr_data;
    if (pm_rden) pm_instr <= mem[pm_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] data; int cyc; } rd_t;
  wr_t wq[$];
  rd_t fq[$];

  int n_cmp = 0, n_err = 0, n_wr = 0;

  // Reference model: image words by address, words loaded, pending low byte.
  logic [15:0] ref_mem [DEPTH];
  int   m_cnt;
  bit   m_run, m_have_lo, m_fetch_ok;
  logic [7:0] m_lo;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!(pm_we == 2'b00 || pm_we == 2'b11) || (pm_rden && pm_we != 2'b00) || (!f_valid && f_instr != 16'h0)) begin
        n_err++;
        $display("FAIL bus_rules: pm_we=%b pm_rden=%b f_valid=%b f_instr=%h; need legal we, no read with write, zero idle instr",
                 pm_we, pm_rden, f_valid, f_instr);
      end
      if (pm_we == 2'b11) begin
        n_wr++;
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr=%h data=%h, no write expected", pm_wr_addr, pm_wr_data);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (pm_wr_addr != w.addr || pm_wr_data != w.data || cyc != w.cyc) begin
            n_err++;
            $display("FAIL write: got %h@%h cyc %0d, expected %h@%h cyc %0d",
                     pm_wr_data, pm_wr_addr, cyc, w.data, w.addr, w.cyc);
          end
        end
      end
      if (f_valid) begin
        n_cmp++;
        if (fq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_fetch: f_instr=%h, no fetch result expected", f_instr);
        end else begin
          rd_t r;
          r = fq.pop_front();
          if (f_instr != r.data || cyc != r.cyc) begin
            n_err++;
            $display("FAIL fetch: got %h cyc %0d, expected %h cyc %0d", f_instr, cyc, r.data, r.cyc);
          end
        end
      end
    end
  end

  function automatic void model_write(logic [15:0] d);
    wr_t w;
    w.addr = m_cnt[AW-1:0];
    w.data = d;
    w.cyc  = cyc;
    wq.push_back(w);
    ref_mem[m_cnt] = d;
    m_cnt++;
    if (m_cnt == DEPTH) m_run = 1'b1;
  endfunction

  function automatic void model_end();
    if (!m_run) begin
      if (m_have_lo) begin
        model_write({PAD, m_lo});
        m_have_lo = 1'b0;
      end
      m_run = 1'b1;
    end
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(logic [7:0] b, bit e);
    ld_valid = 1'b1; ld_byte = b; ld_end = e;
    @(negedge clk);
    chk("ld_ready", ld_ready, !m_run);
    @(posedge clk); #1;
    if (!m_run) begin
      if (m_have_lo) begin
        model_write({b, m_lo});
        m_have_lo = 1'b0;
      end else begin
        m_lo = b;
        m_have_lo = 1'b1;
      end
    end
    if (e) model_end();
    ld_valid = 1'b0; ld_end = 1'b0;
  endtask

  task automatic end_pulse();
    ld_end = 1'b1;
    @(posedge clk); #1;
    model_end();
    ld_end = 1'b0;
  endtask

  task automatic wait_run();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (cpu_run) seen = 1'b1;
    end
    chk("cpu_run_rise", seen, 1);
    chk("ld_count_loaded", ld_count, m_cnt);
    m_fetch_ok = seen;
    @(posedge clk); #1;
  endtask

  task automatic fetch_one(logic [AW-1:0] a);
    rd_t r;
    f_req = 1'b1; f_addr = a;
    @(posedge clk); #1;
    if (m_fetch_ok) begin
      r.data = ref_mem[a];
      r.cyc  = cyc;
      fq.push_back(r);
    end
    f_req = 1'b0;
  endtask

  // One fetch in flight, then boot_req with a colliding fetch.
  task automatic reload();
    fetch_one(AW'($urandom_range(0, DEPTH - 1)));
    boot_req = 1'b1; f_req = 1'b1; f_addr = AW'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    chk("rden_blocked_by_boot_req", pm_rden, 0);
    @(posedge clk); #1;
    boot_req = 1'b0; f_req = 1'b0;
    m_cnt = 0; m_run = 1'b0; m_have_lo = 1'b0; m_fetch_ok = 1'b0;
    @(negedge clk);
    chk("cpu_run_after_reload", cpu_run, 0);
    chk("ld_count_after_reload", ld_count, 0);
    chk("ld_ready_after_reload", ld_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_pm_we", pm_we, 0);
    chk("rst_wr_addr", pm_wr_addr, 0);
    chk("rst_wr_data", pm_wr_data, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_ld_ready", ld_ready, 1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    m_cnt = 0; m_run = 1'b0; m_have_lo = 1'b0; m_fetch_ok = 1'b0; m_lo = 8'h00;
    #3;
    chk_reset_vals();
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Even stream, separate end pulse, then back-to-back fetches 0,1,0.
    base = n_wr;
    send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h78, 0); send_byte(8'h56, 0);
    end_pulse();
    wait_run();
    chk("write_cycles_even", n_wr - base, 2);
    chk("ld_count_even", ld_count, 2);
    fetch_one(0); fetch_one(1); fetch_one(0);
    idle(3);

    // Odd stream: pad word written at address 1.
    reload();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
    end_pulse();
    wait_run();
    chk("ld_count_odd", ld_count, 2);
    chk("ref_odd_word", ref_mem[1], 16'h00CC);
    fetch_one(0); fetch_one(1);
    idle(2);

    // Randomized streams: length, gaps, end style and fetch pattern.
    for (int t = 0; t < 10; t++) begin
      int len;
      reload();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        bit last_with_end;
        last_with_end = (i == len - 1) && ($urandom_range(0, 1) == 1);
        send_byte(8'($urandom), last_with_end);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if (!m_run) end_pulse();
      wait_run();
      for (int k = 0; k < 12; k++) begin
        fetch_one(AW'($urandom_range(0, (len > 1) ? len / 2 : 1)));
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(2);
    end

    // Fill the whole memory without ld_end; extra byte must be refused.
    reload();
    for (int i = 0; i < 2 * DEPTH; i++) send_byte(8'($urandom), 0);
    wait_run();
    chk("ld_count_full", ld_count, DEPTH);
    send_byte(8'hEE, 0);
    idle(2);
    chk("ld_count_full_hold", ld_count, DEPTH);
    for (int k = 0; k < 24; k++) fetch_one(AW'($urandom_range(0, DEPTH - 1)));
    fetch_one(AW'(DEPTH - 1));
    idle(2);

    // Reset mid-stream after the third byte; word 0 survives in memory.
    reload();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    chk("rst_pending_writes", wq.size(), 0);
    m_cnt = 0; m_run = 1'b0; m_have_lo = 1'b0; m_fetch_ok = 1'b0;
    fq.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    end_pulse();
    wait_run();
    chk("ld_count_empty_load", ld_count, 0);
    chk("ref_survivor", ref_mem[0], 16'h2211);
    fetch_one(0); fetch_one(0);
    idle(4);

    chk("writes_drained", wq.size(), 0);
    chk("fetches_drained", fq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pmem_boot_fetch_ctrl.md
Name: pmem_boot_fetch_ctrl

Overview:
- Sole owner of the Program Memory ports.
- Boot phase: assembles a byte stream from the loader (UART/SPI front end) into 16-bit instructions and writes them sequentially from address 0.
- Run phase: serves CPU instruction fetches with fixed 1-cycle latency.
- CPU is held stalled via cpu_run until loading completes; a reload request returns the block to boot.

Parameters:
- ADDR_W, 8, program memory address width; depth = 2**ADDR_W words.
- PAD_BYTE, 8'h00, high byte substituted when the stream ends on an odd byte.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte; little-endian, low byte first
- ld_ready  out  1  controller accepts byte this cycle
- ld_end  in  1  loader end-of-image pulse
- boot_req  in  1  request reload (RUN only)
- f_req  in  1  CPU fetch request
- f_addr  in  ADDR_W  fetch word address
- f_valid  out  1  f_instr valid this cycle
- f_instr  out  16  fetched instruction
- cpu_run  out  1  1 = CPU may fetch and execute
- ld_count  out  ADDR_W+1  words written in current boot
- pm_rden  out  1  to memory rden
- pm_rd_addr  out  ADDR_W  to memory rd_addr
- pm_we  out  2  to memory we; only 2'b11 or 2'b00
- pm_wr_addr  out  ADDR_W  to memory wr_addr
- pm_wr_data  out  16  to memory wr_data
- pm_instr  in  16  from memory instr (registered in memory)

Behaviour:
- Reset values:
  - state = BOOT_LO; ld_count = 0; wr pointer = 0; lo latch = 0.
  - cpu_run = 0; f_valid = 0; pm_we = 00; pm_wr_addr = 0; pm_wr_data = 0.
  - Reset is asynchronous and may occur mid-load; memory contents are not cleared.
- States: BOOT_LO, BOOT_HI, RUN. cpu_run = (state == RUN), registered.
- ld_ready = 1 in BOOT_LO and BOOT_HI, 0 in RUN. A handshake is ld_valid & ld_ready.
- BOOT_LO:
  - Handshake: latch ld_byte as lo, go to BOOT_HI.
  - ld_end without handshake: go to RUN.
  - ld_end with handshake in the same cycle: the byte is accepted as lo, then treated as the odd-byte case below.
- BOOT_HI:
  - Handshake: next cycle (registered) drive pm_we = 11, pm_wr_addr = ptr, pm_wr_data = {ld_byte, lo}. Then ptr += 1, ld_count += 1.
  - After the write, go to BOOT_LO, or to RUN if ld_end was seen or ld_count reaches 2**ADDR_W.
  - ld_end without handshake: write {PAD_BYTE, lo} the same way, then go to RUN.
- Writes are one cycle wide. pm_we returns to 00 the cycle after each write.
- ld_count saturates at 2**ADDR_W. Once full, the block enters RUN and further bytes are not accepted (ld_ready = 0).
- RUN:
  - pm_rden = f_req and pm_rd_addr = f_addr, both combinational. pm_rden = 0 in the boot states.
  - f_valid = f_req delayed by one cycle (registered). f_instr = pm_instr when f_valid, else 0.
  - Back-to-back fetches give one result per cycle.
- boot_req in RUN:
  - Next state BOOT_LO; ptr = 0; ld_count = 0; cpu_run = 0 from the next cycle.
  - A fetch in the same cycle as boot_req is suppressed: pm_rden = 0, no f_valid follows.
  - An f_valid already in flight from the previous cycle still completes.
- boot_req in boot states: ignored.
- ld_valid in RUN: ignored; no write.
- No read and write are ever issued in the same cycle.

Test Plan:
- Reset, then bytes 34,12,78,56, then ld_end → writes 0x1234 @0 and 0x5678 @1. pm_we = 11 for exactly 2 cycles. ld_count = 2. cpu_run = 1.
- Odd stream: bytes AA,BB,CC, then ld_end → writes 0xBBAA @0 and 0x00CC @1. Then RUN.
- RUN with f_req on consecutive cycles, addrs 0,1,0 → f_valid on 3 consecutive cycles, each one cycle after its request. f_instr = 1234, 5678, 1234.
- Stream 512 bytes without ld_end → 256 writes (addr 0..255). ld_count = 256. Enters RUN. ld_ready = 0; a 513th byte is not accepted.
- boot_req together with f_req in RUN → no pm_rden that cycle, cpu_run drops next cycle, ld_count = 0. New stream writes again from addr 0.
- rst_n low mid-stream after byte 3 → all outputs return to reset values immediately. Earlier written word @0 is still readable after a fresh load plus ld_end.
